// File: rtl/hnf_pocq_sched.sv
// HN-F point-of-coherency queue: holds request flits, sleeps same-line followers,
// issues oldest awake entry. Optional perf counters under HNF_POCQ_PERF_EN.
//
// Ports: clock, reset (async, active-low)
//   alloc_valid/alloc_ready/alloc_flit/alloc_addr/alloc_idx : request intake
//   issue_valid/issue_ready/issue_flit/issue_idx           : pipeline issue
//   retire_valid/retire_idx                                : entry release
//   full/empty/count                                       : occupancy
//   peak_count/full_stall_cnt                              : only with HNF_POCQ_PERF_EN
module hnf_pocq_sched #(
  parameter int DEPTH  = 16,
  parameter int FLIT_W = 128,
  parameter int ADDR_W = 42,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [FLIT_W-1:0] alloc_flit,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic [IDX_W-1:0]  alloc_idx,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [FLIT_W-1:0] issue_flit,
  output logic [IDX_W-1:0]  issue_idx,
  input  logic              retire_valid,
  input  logic [IDX_W-1:0]  retire_idx,
  output logic              full,
  output logic              empty,
  output logic [IDX_W:0]    count
`ifdef HNF_POCQ_PERF_EN
  ,
  output logic [IDX_W:0]    peak_count,
  output logic [31:0]       full_stall_cnt
`endif
);

  typedef logic [DEPTH-1:0][DEPTH-1:0] age_t;

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  sleep_q;
  logic [DEPTH-1:0]  issued_q;
  age_t              age_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [FLIT_W-1:0] flit_q [DEPTH];
  logic [IDX_W:0]    count_q;
  logic [IDX_W:0]    count_d;
  logic              hold_q;
  logic [IDX_W-1:0]  hold_idx_q;

  logic              alloc_fire;
  logic              retire_fire;
  logic              issue_fire;
  logic              hazard;
  logic [DEPTH-1:0]  icand;
  logic [DEPTH-1:0]  wcand;
  logic [IDX_W-1:0]  wake_idx;
  logic              wake_any;
  logic [ADDR_W-1:0] ret_addr;

  // age[k][i] = k older than i; one-hot of the candidate nobody older beats
  function automatic logic [DEPTH-1:0] pick_oldest(
    input logic [DEPTH-1:0] c,
    input age_t             age
  );
    logic [DEPTH-1:0] oh;
    logic             beat;
    oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      beat = 1'b0;
      for (int k = 0; k < DEPTH; k++)
        if (c[k] && age[k][i]) beat = 1'b1;
      oh[i] = c[i] & ~beat;
    end
    return oh;
  endfunction

  function automatic logic [IDX_W-1:0] enc(input logic [DEPTH-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (oh[i]) idx = idx | IDX_W'(i);
    return idx;
  endfunction

  assign count       = count_q;
  assign full        = (count_q == (IDX_W+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign alloc_ready = ~full;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign retire_fire = retire_valid & valid_q[retire_idx]
                     & issued_q[retire_idx];
  assign ret_addr    = addr_q[retire_idx];

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
  end

  // Retiring entry no longer blocks; a woken same-line entry still does.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (valid_q[i] && addr_q[i] == alloc_addr
          && !(retire_fire && retire_idx == IDX_W'(i)))
        hazard = 1'b1;
  end

  always_comb begin
    wcand = '0;
    for (int i = 0; i < DEPTH; i++)
      wcand[i] = valid_q[i] & sleep_q[i] & (addr_q[i] == ret_addr);
    wake_idx = enc(pick_oldest(wcand, age_q));
    wake_any = retire_fire & (|wcand);
  end

  // A stalled offer is pinned: a just-woken older entry must not
  // displace it while the pipeline is back-pressuring.
  always_comb begin
    icand       = valid_q & ~sleep_q & ~issued_q;
    issue_valid = |icand;
    issue_idx   = hold_q ? hold_idx_q : enc(pick_oldest(icand, age_q));
    issue_flit  = flit_q[issue_idx];
  end

  assign issue_fire = issue_valid & issue_ready;
  assign count_d    = count_q + (IDX_W+1)'(alloc_fire)
                    - (IDX_W+1)'(retire_fire);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      sleep_q    <= '0;
      issued_q   <= '0;
      age_q      <= '0;
      count_q    <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      count_q    <= count_d;
      hold_q     <= issue_valid & ~issue_ready;
      hold_idx_q <= issue_idx;
      if (issue_fire) issued_q[issue_idx] <= 1'b1;
      if (retire_fire) begin
        valid_q[retire_idx]  <= 1'b0;
        issued_q[retire_idx] <= 1'b0;
        sleep_q[retire_idx]  <= 1'b0;
      end
      if (wake_any) sleep_q[wake_idx] <= 1'b0;
      if (alloc_fire) begin
        valid_q[alloc_idx]  <= 1'b1;
        sleep_q[alloc_idx]  <= hazard;
        issued_q[alloc_idx] <= 1'b0;
        for (int j = 0; j < DEPTH; j++)
          age_q[j][alloc_idx] <= valid_q[j];
        age_q[alloc_idx] <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (alloc_fire) begin
      addr_q[alloc_idx] <= alloc_addr;
      flit_q[alloc_idx] <= alloc_flit;
    end
  end

`ifdef HNF_POCQ_PERF_EN
  logic [IDX_W:0] peak_q;
  logic [31:0]    stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      peak_q  <= '0;
      stall_q <= '0;
    end else begin
      if (count_d > peak_q) peak_q <= count_d;
      if (alloc_valid && full && stall_q != '1)
        stall_q <= stall_q + 32'd1;
    end
  end

  assign peak_count     = peak_q;
  assign full_stall_cnt = stall_q;
`endif

endmodule
